// File: rtl/clock_domain_exporter_fifo_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the toggle req/ack clock-domain-crossing FIFOs.
// The exporter (source side) uses the state type below; the importer FIFO
// variant is expected to import the same package.
// ---------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } exporter_state_t;

endpackage

// File: rtl/clock_domain_exporter_fifo_sync.sv
// ---------------------------------------------------------------------------
// cdc_synchronizer
// Generic multi-flop synchronizer chain with asynchronous active-high reset
// to zero. Used for the ack on the exporter side and the req on the
// importer side.
//
// Ports:
//   clk_i   destination-domain clock
//   rst_i   asynchronous active-high reset (chain cleared to 0)
//   data_i  asynchronous input (Bits wide)
//   data_o  synchronised output, last stage of the chain
// ---------------------------------------------------------------------------
module cdc_synchronizer #(
    parameter int unsigned Stages = 2,
    parameter int unsigned Bits   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [Bits-1:0] data_i,
    output logic [Bits-1:0] data_o
);

    logic [Bits-1:0] chain [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Stages; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= data_i;
            for (int unsigned i = 1; i < Stages; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign data_o = chain[Stages-1];

endmodule

// File: rtl/clock_domain_exporter_fifo.sv
// ---------------------------------------------------------------------------
// clock_domain_exporter_fifo
// Source-side half of a toggle req/ack clock-domain crossing, with a
// Depth-entry FIFO in front so the producer can queue words while a
// transfer is in flight. Each word is launched by loading cdc_data_o and
// toggling cdc_req_o on the same edge; the next launch waits until the
// synchronised ack matches req again.
//
// Ports:
//   clk_i       producer clock (only clock)
//   rst_i       asynchronous active-high reset
//   stb_i       push request, accepted only while ready_o=1
//   data_i      word to push
//   ready_o     registered FIFO-not-full
//   level_o     FIFO occupancy, excluding the word in flight
//   busy_o      FIFO non-empty or transfer awaiting ack
//   overflow_o  sticky: a push was attempted while ready_o=0
//   cdc_req_o   toggle request to the importer
//   cdc_data_o  word in flight, stable while req != synchronised ack
//   cdc_ack_i   toggle acknowledge from the importer (asynchronous)
// ---------------------------------------------------------------------------
module clock_domain_exporter_fifo
    import cdc_pkg::*;
#(
    parameter int unsigned Bits       = 8,
    parameter int unsigned Depth      = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stb_i,
    input  logic [Bits-1:0]          data_i,
    output logic                     ready_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic                     cdc_req_o,
    output logic [Bits-1:0]          cdc_data_o,
    input  logic                     cdc_ack_i
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;

    logic [Bits-1:0]  mem [Depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q, level_next;
    logic             ready_q, overflow_q;
    logic             req_q;
    logic [Bits-1:0]  data_q;
    exporter_state_t  state_q;
    logic             ack_sync;
    logic             push, pop;

    cdc_synchronizer #(
        .Stages (SyncStages),
        .Bits   (1)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (cdc_ack_i),
        .data_o (ack_sync)
    );

    assign push = stb_i && ready_q;
    assign pop  = (state_q == IDLE) && (level_q != '0);

    always_comb begin
        level_next = level_q;
        case ({push, pop})
            2'b10:   level_next = level_q + LW'(1);
            2'b01:   level_next = level_q - LW'(1);
            default: level_next = level_q;
        endcase
    end

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // ready is registered from the post-update level, so a pop only
    // re-opens the FIFO on the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_next;
            ready_q <= (level_next != LW'(Depth));
            if (stb_i && !ready_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Launch FSM: data and req update on the same edge so the importer
    // never sees a toggled req with stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem[rd_ptr];
                        req_q   <= ~req_q;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_sync == req_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign cdc_req_o  = req_q;
    assign cdc_data_o = data_q;
    assign busy_o     = (level_q != '0) || (state_q == WAIT_ACK);

endmodule

// File: tb/tb_clock_domain_exporter_fifo.sv
// ---------------------------------------------------------------------------
// tb_clock_domain_exporter_fifo
// Self-checking bench: directed stimulus pushes expected launches into a
// scoreboard queue; a monitor pops and compares on every cdc_req_o toggle.
// A loopback importer returns the ack three cycles after each req toggle
// while enabled.
// ---------------------------------------------------------------------------
module tb_clock_domain_exporter_fifo;

    logic       clk_i;
    logic       rst_i;
    logic       stb_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic [2:0] level_o;
    logic       busy_o;
    logic       overflow_o;
    logic       cdc_req_o;
    logic [7:0] cdc_data_o;
    logic       cdc_ack_i;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];
    logic       exp_req = 1'b0;
    logic       ack_en  = 1'b0;

    clock_domain_exporter_fifo #(
        .Bits       (8),
        .Depth      (4),
        .SyncStages (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stb_i      (stb_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .level_o    (level_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .cdc_req_o  (cdc_req_o),
        .cdc_data_o (cdc_data_o),
        .cdc_ack_i  (cdc_ack_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_req = ~exp_req;
        exp_q.push_back({exp_req, d});
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        stb_i  = 1'b0;
        ack_en = 1'b0;
        exp_q.delete();
        exp_req = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o || level_o != 3'd0) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL %s: busy_o=%0b after %0d cycles, required 0", name, busy_o, n);
        end
    endtask

    // Loopback importer: returns the req parity 3 cycles after it changes.
    initial begin
        int cnt;
        cnt = 0;
        cdc_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                cdc_ack_i = 1'b0;
                cnt = 0;
            end else if (ack_en && cdc_req_o != cdc_ack_i) begin
                cnt++;
                if (cnt == 3) begin
                    cdc_ack_i = cdc_req_o;
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: every req toggle is one launch.
    initial begin
        logic       last_req;
        logic [8:0] e;
        last_req = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                last_req = 1'b0;
            end else if (cdc_req_o !== last_req) begin
                last_req = cdc_req_o;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL launch_unexpected: got data %0h, expected no launch", cdc_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("launch_data", 32'(cdc_data_o), 32'(e[7:0]));
                    chk("launch_req", 32'(cdc_req_o), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        int k;
        int n;
        logic prev_ready;
        rst_i  = 1'b1;
        stb_i  = 1'b0;
        data_i = 8'h00;

        // Reset state
        do_reset();
        step();
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_req", 32'(cdc_req_o), 0);
        chk("rst_data", 32'(cdc_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);

        // Single word, loopback ack
        ack_en = 1'b1;
        stb_i  = 1'b1;
        data_i = 8'hA5;
        push_exp(8'hA5);
        step();
        stb_i = 1'b0;
        chk("a5_level", 32'(level_o), 1);
        chk("a5_req_pre", 32'(cdc_req_o), 0);
        step();
        chk("a5_req", 32'(cdc_req_o), 1);
        chk("a5_data", 32'(cdc_data_o), 32'h A5);
        chk("a5_level_post", 32'(level_o), 0);
        chk("a5_busy", 32'(busy_o), 1);
        k = 0;
        while (cdc_ack_i != cdc_req_o && k < 20) begin
            step();
            k++;
        end
        chk("a5_ack_delay", 32'(k), 2);
        n = 0;
        while (busy_o && n < 20) begin
            step();
            n++;
        end
        chk("a5_busy_fall_edges", 32'(n), 3);
        chk("a5_drained", 32'(exp_q.size()), 0);

        // Four back-to-back pushes, ack held
        do_reset();
        stb_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_i = 8'(i);
            push_exp(8'(i));
            step();
            if (i == 2) chk("b2b_push_pop_level", 32'(level_o), 1);
        end
        stb_i = 1'b0;
        chk("b2b_level_peak", 32'(level_o), 3);
        chk("b2b_ready", 32'(ready_o), 1);
        ack_en = 1'b1;
        wait_idle("b2b_drain");
        chk("b2b_drained", 32'(exp_q.size()), 0);

        // Overflow with the ack stalled
        do_reset();
        stb_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 8'h11 + 8'(i);
            push_exp(8'h11 + 8'(i));
            step();
        end
        chk("full_ready", 32'(ready_o), 0);
        chk("full_level", 32'(level_o), 4);
        chk("full_ovf_pre", 32'(overflow_o), 0);
        data_i = 8'h16;
        step();
        chk("ovf_set", 32'(overflow_o), 1);
        chk("ovf_level", 32'(level_o), 4);

        // Full FIFO, ack arrives with stb_i held
        data_i = 8'h17;
        push_exp(8'h17);
        ack_en = 1'b1;
        prev_ready = ready_o;
        n = 0;
        while (level_o == 3'd4 && n < 40) begin
            prev_ready = ready_o;
            step();
            n++;
        end
        chk("pop_ready_before", 32'(prev_ready), 0);
        chk("pop_ready_after", 32'(ready_o), 1);
        chk("pop_level", 32'(level_o), 3);
        step();
        stb_i = 1'b0;
        chk("refill_level", 32'(level_o), 4);
        chk("refill_ready", 32'(ready_o), 0);
        chk("ovf_sticky", 32'(overflow_o), 1);
        wait_idle("full_drain");
        chk("full_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-transfer
        do_reset();
        stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'h31 + 8'(i);
            push_exp(8'h31 + 8'(i));
            step();
        end
        stb_i = 1'b0;
        step();
        chk("mid_busy", 32'(busy_o), 1);
        chk("mid_level", 32'(level_o), 2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_req", 32'(cdc_req_o), 0);
        chk("arst_data", 32'(cdc_data_o), 0);
        chk("arst_level", 32'(level_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_ready", 32'(ready_o), 1);
        exp_q.delete();
        exp_req = 1'b0;
        step();
        step();
        rst_i  = 1'b0;
        ack_en = 1'b1;
        stb_i  = 1'b1;
        data_i = 8'h3C;
        push_exp(8'h3C);
        step();
        stb_i = 1'b0;
        step();
        chk("post_rst_req", 32'(cdc_req_o), 1);
        chk("post_rst_data", 32'(cdc_data_o), 32'h3C);
        wait_idle("post_rst_drain");
        chk("post_rst_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
